// File: rtl/pipeline_pkg.sv
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared pipeline constants and the IF/ID bundle used by fetch
//               and decode.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage_if.sv
// ============================================================================
// Module      : fetch_stage_if
// Description : Instruction-memory, hazard/redirect and IF/ID signal bundle
//               of the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_stage_if;
  import pipeline_pkg::*;

  logic [31:0] IM_Addr;
  logic [31:0] IM_Instr;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic [31:0] PC;
  logic [31:0] IFID_Instr;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
  logic        AddrFault;

  modport master (
    output IM_Addr, PC, IFID_Instr, IFID_PCPlus4, IFID_Valid, AddrFault,
    input  IM_Instr, Stall, Redirect, RedirectTarget
  );

  modport slave (
    input  IM_Addr, PC, IFID_Instr, IFID_PCPlus4, IFID_Valid, AddrFault,
    output IM_Instr, Stall, Redirect, RedirectTarget
  );

endinterface

`default_nettype wire

// File: rtl/fetch_pc_reg.sv
// ============================================================================
// Module      : fetch_pc_reg
// Description : Program counter with next-PC select (reset/redirect/stall/+4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_reg
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  // Wraps naturally from 32'hFFFF_FFFC to 0.
  assign pc_plus4 = pc + WORD_BYTES;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_VECTOR;
    end else if (redirect) begin
      pc <= word_align(redirect_target);
    end else if (!stall) begin
      pc <= pc_plus4;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch with IF/ID register, stall, redirect and
//               sticky out-of-range fault. Define FETCH_DELAY_SLOT_EN to keep
//               the in-flight instruction on redirect (branch-delay slot).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS   = 1024
) (
  input  logic          Clk,
  input  logic          Reset,
  fetch_stage_if.master fif
);

  localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_WORDS) * 33'd4;

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        advance;
  logic        fault_now;
  logic        addr_fault;
  ifid_t       ifid_d;
  ifid_t       ifid_q;

  fetch_pc_reg #(
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_reg (
    .clk             (Clk),
    .rst             (Reset),
    .stall           (fif.Stall),
    .redirect        (fif.Redirect),
    .redirect_target (fif.RedirectTarget),
    .pc              (pc),
    .pc_plus4        (pc_plus4)
  );

  // Redirect overrides stall, so the pipeline register moves whenever either allows it.
  assign advance   = fif.Redirect | ~fif.Stall;
  assign fault_now = {1'b0, pc} >= IMEM_LIMIT;

  always_comb begin
    ifid_d = '{instr: fif.IM_Instr, pc_plus4: pc_plus4, valid: 1'b1};
`ifndef FETCH_DELAY_SLOT_EN
    if (fif.Redirect) begin
      ifid_d = '{instr: NOP_INSTR, pc_plus4: pc_plus4, valid: 1'b0};
    end
`endif
    if (fault_now) begin
      ifid_d = '{instr: NOP_INSTR, pc_plus4: pc_plus4, valid: 1'b0};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ifid_q     <= '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};
      addr_fault <= 1'b0;
    end else if (advance) begin
      ifid_q <= ifid_d;
      if (fault_now) begin
        addr_fault <= 1'b1;
      end
    end
  end

  assign fif.IM_Addr      = pc;
  assign fif.PC           = pc;
  assign fif.IFID_Instr   = ifid_q.instr;
  assign fif.IFID_PCPlus4 = ifid_q.pc_plus4;
  assign fif.IFID_Valid   = ifid_q.valid;
  assign fif.AddrFault    = addr_fault;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module      : tb_fetch_stage
// Description : Scoreboard bench for fetch_stage with a small instruction
//               memory so out-of-range fetches are reachable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  localparam logic [31:0] RV         = 32'h0000_0000;
  localparam int unsigned IMEM_WORDS = 16;
  localparam longint      LIMIT      = longint'(IMEM_WORDS) * 4;
`ifdef FETCH_DELAY_SLOT_EN
  localparam bit DELAY_SLOT = 1'b1;
`else
  localparam bit DELAY_SLOT = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcp4;
    logic        valid;
    logic        fault;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference state
  logic [31:0] m_pc    = RV;
  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_pcp4  = 32'h0;
  logic        m_valid = 1'b0;
  logic        m_fault = 1'b0;

  fetch_stage_if fif ();

  fetch_stage #(
    .RESET_VECTOR (RV),
    .IMEM_WORDS   (IMEM_WORDS)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .fif   (fif.master)
  );

  always #5 clk = ~clk;

  // Instruction memory: each word's contents identify its address.
  assign fif.IM_Instr = 32'h2008_0000 + fif.IM_Addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2008_0000 + a;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic s, input logic rd, input logic [31:0] t);
    bit   bad;
    exp_t e;
    @(negedge clk);
    rst                = r;
    fif.Stall          = s;
    fif.Redirect       = rd;
    fif.RedirectTarget = t;
    if (r) begin
      m_pc = RV; m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0; m_fault = 1'b0;
    end else if (rd || !s) begin
      bad     = longint'(m_pc) >= LIMIT;
      m_valid = !(bad || (rd && !DELAY_SLOT));
      m_instr = m_valid ? mem_word(m_pc) : 32'h0;
      m_pcp4  = m_pc + 32'd4;
      m_fault = m_fault | bad;
      m_pc    = rd ? (t & 32'hFFFF_FFFC) : m_pc + 32'd4;
    end
    e.pc = m_pc; e.instr = m_instr; e.pcp4 = m_pcp4; e.valid = m_valid; e.fault = m_fault;
    sb.push_back(e);
  endtask

  // Monitor: one expectation per clock edge issued by the stimulus.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("pc",           fif.PC,           e.pc);
        check("im_addr",      fif.IM_Addr,      e.pc);
        check("ifid_instr",   fif.IFID_Instr,   e.instr);
        check("ifid_pcplus4", fif.IFID_PCPlus4, e.pcp4);
        check("ifid_valid",   32'(fif.IFID_Valid), 32'(e.valid));
        check("addr_fault",   32'(fif.AddrFault),  32'(e.fault));
      end
    end
  end

  initial begin
    logic r, s, rd;
    logic [31:0] t;
    fif.Stall = 1'b0; fif.Redirect = 1'b0; fif.RedirectTarget = 32'h0;

    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0);          // PC 4, 8
    repeat (3) cycle(0, 1, 0, 0);          // hold at 8
    cycle(0, 0, 0, 0);                      // PC C
    cycle(0, 0, 1, 32'h43);                 // redirect -> 0x40 from C
    cycle(0, 0, 1, 32'h10);                 // fetch at 0x40 faults during redirect
    cycle(0, 1, 1, 32'h21);                 // redirect beats stall
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 32'h34);
    repeat (5) cycle(0, 0, 0, 0);           // passes 0x3C then faults at 0x40
    cycle(0, 0, 1, 32'h0);                  // fault stays sticky
    repeat (2) cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 32'h20);
    repeat (2) cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);                      // reset mid-stall
    cycle(0, 0, 0, 0);
    cycle(0, 0, 1, 32'hFFFF_FFFE);          // wrap region
    repeat (2) cycle(0, 0, 0, 0);
    cycle(1, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 39) == 0);
      s  = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 5) == 0);
      t  = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 80));
      cycle(r, s, rd, t);
    end

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
